// File: rtl/cpu_pkg.sv
// Shared CPU constants: processor modes, PC read alias and operand-fetch FSM states.
package cpu_pkg;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] FIQ = 5'b10001;
  localparam logic [4:0] IRQ = 5'b10010;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] ABT = 5'b10111;
  localparam logic [4:0] UND = 5'b11011;
  localparam logic [4:0] SYS = 5'b11111;

  // Reading r15 returns the instruction address plus the pipeline offset.
  localparam logic [3:0]  PC_IDX         = 4'd15;
  localparam int unsigned PC_READ_OFFSET = 8;

  typedef enum logic [0:0] {StRun, StModeDrain} of_state_e;

  // One-hot register mask, all zero when not enabled.
  function automatic logic [15:0] reg_mask(input logic en, input logic [3:0] idx);
    return en ? (16'b1 << idx) : 16'b0;
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one bit per logical register plus RAW/WAW/mode hazard detection.
module opfetch_scoreboard
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic        set_en,
  input  logic [3:0]  set_addr,
  input  logic        kill_en,
  input  logic [3:0]  kill_addr,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  src_c,
  input  logic [2:0]  src_use,
  input  logic        rd_we,
  input  logic [3:0]  rd,
  input  logic [4:0]  mode,
  input  logic [4:0]  cur_mode,
  output logic        raw_hazard,
  output logic        waw_hazard,
  output logic        mode_hazard,
  output logic        drained
);

  logic [15:0] sb_q, sb_d;
  logic [15:0] sb_wb;   // after this cycle's write-back clear
  logic [15:0] sb_clr;  // after write-back and flush-kill clears

  // Clear first, then set: a same-cycle clear/set on one register leaves it pending.
  always_comb begin
    sb_wb  = sb_q & ~reg_mask(wb_en, wb_addr);
    sb_clr = sb_wb & ~reg_mask(kill_en, kill_addr);
    sb_d   = sb_clr | reg_mask(set_en, set_addr);
  end

  // Hazards look past a same-cycle write-back since that value is forwarded.
  always_comb begin
    raw_hazard  = (src_use[0] && sb_wb[src_a]) ||
                  (src_use[1] && sb_wb[src_b]) ||
                  (src_use[2] && sb_wb[src_c]);
    waw_hazard  = rd_we && sb_wb[rd];
    mode_hazard = (mode != cur_mode) && (sb_wb != 16'b0);
    drained     = (sb_clr == 16'b0);
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= 16'b0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, forwarding, hazard stall and output slot to execute.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mode,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [3:0]        in_rs,
  input  logic [2:0]        in_use,
  input  logic [3:0]        in_rd,
  input  logic              in_rd_we,
  input  logic [DW-1:0]     in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [3:0]        r_addr_a,
  output logic [3:0]        r_addr_b,
  output logic [3:0]        r_addr_c,
  output logic [4:0]        M,
  input  logic [DW-1:0]     r_data_a,
  input  logic [DW-1:0]     r_data_b,
  input  logic [DW-1:0]     r_data_c,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_op_a,
  output logic [DW-1:0]     out_op_b,
  output logic [DW-1:0]     out_op_c,
  output logic [3:0]        out_rd,
  output logic              out_rd_we,
  output logic [DW-1:0]     out_pc,
  output logic [CTRL_W-1:0] out_ctrl
);

  of_state_e   state_q, state_d;
  logic [4:0]  cur_mode_q, cur_mode_d;
  logic        raw_hazard, waw_hazard, mode_hazard, drained;
  logic        hazard, accept, kill;
  logic [DW-1:0] op_a, op_b, op_c;

  // r15 beats forwarding, forwarding beats the register file; unused sources read as 0.
  function automatic logic [DW-1:0] sel_op(input logic used, input logic [3:0] s,
                                           input logic [DW-1:0] rf, input logic [DW-1:0] pc,
                                           input logic fwd_en, input logic [3:0] fwd_addr,
                                           input logic [DW-1:0] fwd_data);
    if (!used)                             return '0;
    else if (s == PC_IDX)                  return pc + DW'(PC_READ_OFFSET);
    else if (fwd_en && (fwd_addr == s))    return fwd_data;
    else                                   return rf;
  endfunction

  assign r_addr_a = in_rn;
  assign r_addr_b = in_rm;
  assign r_addr_c = in_rs;
  assign M        = in_mode;

  // Resolve the three operands for the instruction presented this cycle.
  always_comb begin
    op_a = sel_op(in_use[0], in_rn, r_data_a, in_pc, wb_en, wb_addr, wb_data);
    op_b = sel_op(in_use[1], in_rm, r_data_b, in_pc, wb_en, wb_addr, wb_data);
    op_c = sel_op(in_use[2], in_rs, r_data_c, in_pc, wb_en, wb_addr, wb_data);
  end

  // Handshake: stall on hazard, mode drain, full slot or flush.
  always_comb begin
    hazard   = raw_hazard || waw_hazard || mode_hazard;
    in_ready = (state_q == StRun) && !hazard && (!out_valid || out_ready) && !flush;
    accept   = in_valid && in_ready;
    kill     = flush && out_valid && out_rd_we;
  end

  opfetch_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .set_en      (accept && in_rd_we),
    .set_addr    (in_rd),
    .kill_en     (kill),
    .kill_addr   (out_rd),
    .src_a       (in_rn),
    .src_b       (in_rm),
    .src_c       (in_rs),
    .src_use     (in_use),
    .rd_we       (in_rd_we),
    .rd          (in_rd),
    .mode        (in_mode),
    .cur_mode    (cur_mode_q),
    .raw_hazard  (raw_hazard),
    .waw_hazard  (waw_hazard),
    .mode_hazard (mode_hazard),
    .drained     (drained)
  );

  // Mode FSM: drain all pending writes before switching to a new mode.
  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          cur_mode_d = in_mode;
        end else if (in_valid && mode_hazard && !raw_hazard && !waw_hazard) begin
          state_d = StModeDrain;
        end
      end
      StModeDrain: begin
        if (drained) begin
          state_d    = StRun;
          cur_mode_d = in_mode;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // FSM state and current mode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      cur_mode_q <= SVC;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
    end
  end

  // Output slot: load on accept, drop on flush (wins over out_ready) or consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op_a  <= '0;
      out_op_b  <= '0;
      out_op_c  <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      out_pc    <= '0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op_a  <= op_a;
      out_op_b  <= op_b;
      out_op_c  <= op_c;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
      out_pc    <= in_pc;
      out_ctrl  <= in_ctrl;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
